ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multiply/divide sequencer (MULT, MADD/MSUB, DIV)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_i[5:0]      pipeline stall vector; bit 4 set = MEM stage stopped (hold)
//   flush             exception flush, abandons any operation in progress
//   aluop_i[7:0]      operation from ID/EX
//   reg1_i, reg2_i    rs / rt operands
//   hi_i, lo_i        current HI/LO (already forwarded)
//   hi_o, lo_o        HI/LO write-back value
//   whilo_o           HI/LO write enable
//   stallreq_o        EX stall request to the pipeline controller
module ex_muldiv #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;
    localparam logic       STOP     = 1'b1;
    localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE, MAC_2ND} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [63:0] temp;
    logic [64:0] rq;        // [64:32] partial remainder, [31:0] dividend shifting into quotient
    logic [31:0] divisor;
    logic        q_neg;
    logic        r_neg;

    logic is_mul, is_mac, is_div, is_sub, op_signed, hold;
    logic [63:0] a_ext, b_ext, product, mac_sum;
    logic [31:0] dividend_mag, divisor_mag, quotient_fix, remainder_fix;
    logic [64:0] shifted, step;
    logic [32:0] diff;
    logic        unused_stall;

    assign is_mul    = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
    assign is_mac    = (aluop_i == OP_MADD) || (aluop_i == OP_MADDU) ||
                       (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
    assign is_div    = (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
    assign is_sub    = (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
    assign op_signed = (aluop_i == OP_MULT) || (aluop_i == OP_MADD) ||
                       (aluop_i == OP_MSUB) || (aluop_i == OP_DIV);
    assign hold      = (stall_i[4] == STOP);
    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    // One 64x64 multiplier serves both signednesses: the low 64 bits of the
    // product of sign-extended operands equal the signed 32x32 product.
    assign a_ext   = {{32{op_signed & reg1_i[31]}}, reg1_i};
    assign b_ext   = {{32{op_signed & reg2_i[31]}}, reg2_i};
    assign product = a_ext * b_ext;
    assign mac_sum = is_sub ? ({hi_i, lo_i} - temp) : ({hi_i, lo_i} + temp);

    assign dividend_mag = (op_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign divisor_mag  = (op_signed && reg2_i[31]) ? -reg2_i : reg2_i;

    // Restoring step: shift, trial-subtract from the upper bits, keep on non-negative.
    assign shifted = {rq[63:0], 1'b0};
    assign diff    = shifted[64:32] - {1'b0, divisor};
    assign step    = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

    assign quotient_fix  = q_neg ? -rq[31:0]  : rq[31:0];
    assign remainder_fix = r_neg ? -rq[63:32] : rq[63:32];

    always_comb begin
        state_next = state;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        whilo_o    = 1'b0;
        stallreq_o = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        {hi_o, lo_o} = product;
                        whilo_o      = 1'b1;
                    end else if (is_mac) begin
                        stallreq_o = 1'b1;
                        state_next = MAC_2ND;
                    end else if (is_div) begin
                        stallreq_o = 1'b1;
                        state_next = (reg2_i == 32'd0) ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    stallreq_o = 1'b1;
                    if (cnt == LAST_ITER) begin
                        state_next = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    hi_o    = remainder_fix;
                    lo_o    = quotient_fix;
                    whilo_o = 1'b1;
                    if (!hold) begin
                        state_next = IDLE;
                    end
                end
                MAC_2ND: begin
                    {hi_o, lo_o} = mac_sum;
                    whilo_o      = 1'b1;
                    if (!hold) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            temp    <= 64'd0;
            rq      <= 65'd0;
            divisor <= 32'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            state <= state_next;
            if (flush) begin
                cnt <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= 5'd0;
                        if (is_mac) begin
                            temp <= product;
                        end
                        if (is_div) begin
                            if (reg2_i == 32'd0) begin
                                // Divide by zero reports quotient = remainder = 0.
                                rq    <= 65'd0;
                                q_neg <= 1'b0;
                                r_neg <= 1'b0;
                            end else begin
                                rq      <= {33'd0, dividend_mag};
                                divisor <= divisor_mag;
                                q_neg   <= op_signed & (reg1_i[31] ^ reg2_i[31]);
                                r_neg   <= op_signed & reg1_i[31];
                            end
                        end
                    end
                    DIV_BUSY: begin
                        rq  <= step;
                        cnt <= cnt + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
module tb_ex_muldiv;

    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;
    localparam logic [7:0] OP_NOP   = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        flush = 1'b0;
    logic [7:0]  aluop = OP_NOP;
    logic [31:0] reg1 = 32'd0, reg2 = 32'd0, hi_in = 32'd0, lo_in = 32'd0;
    logic [31:0] hi_out, lo_out;
    logic        whilo, stallreq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.DIV_ITER(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush(flush),
        .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2), .hi_i(hi_in), .lo_i(lo_in),
        .hi_o(hi_out), .lo_o(lo_out), .whilo_o(whilo), .stallreq_o(stallreq)
    );

    // Architectural result of one operation, from plain arithmetic.
    function automatic void model(input logic [7:0] op, input logic [31:0] a, b, hin, lin,
                                  output logic [31:0] ehi, elo, output logic ew,
                                  output int estall);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ehi = 32'd0; elo = 32'd0; ew = 1'b0; estall = 0;
        case (op)
            OP_MULT:  begin p = sa * sb; {ehi, elo} = p; ew = 1'b1; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {ehi, elo} = p; ew = 1'b1; end
            OP_MADD:  begin p = sa * sb; {ehi, elo} = {hin, lin} + p; ew = 1'b1; estall = 1; end
            OP_MADDU: begin p = {32'd0, a} * {32'd0, b}; {ehi, elo} = {hin, lin} + p; ew = 1'b1; estall = 1; end
            OP_MSUB:  begin p = sa * sb; {ehi, elo} = {hin, lin} - p; ew = 1'b1; estall = 1; end
            OP_MSUBU: begin p = {32'd0, a} * {32'd0, b}; {ehi, elo} = {hin, lin} - p; ew = 1'b1; estall = 1; end
            OP_DIV, OP_DIVU: begin
                ew = 1'b1;
                if (b == 32'd0) begin
                    estall = 1;
                end else begin
                    estall = 33;
                    if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
                    else begin q = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b}; end
                    elo = q[31:0];
                    ehi = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Issues one op and runs it to its first non-stalled cycle; stalls = -1 on timeout.
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, b, hin, lin,
                         output int stalls, output int wb_stall,
                         output logic [31:0] hi, lo, output logic w);
        @(posedge clk); #1;
        aluop = op; reg1 = a; reg2 = b; hi_in = hin; lo_in = lin;
        stalls = -1; wb_stall = 0; hi = 32'hx; lo = 32'hx; w = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stallreq) begin
                if (whilo) wb_stall++;
                if (i > 0) begin @(posedge clk); #1; end
            end else begin
                stalls = i; hi = hi_out; lo = lo_out; w = whilo;
                break;
            end
        end
    endtask

    // Stall cycles re-enter the loop after the next edge; the first iteration already owns one.
    task automatic step_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; aluop = OP_NOP;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hi_out, lo_out, whilo, stallreq} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got hi=%h lo=%h w=%b s=%b required all zero", hi_out, lo_out, whilo, stallreq);
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_mult();
        int st, wbs; logic [31:0] h, l; logic w;
        do_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd0, 32'h0, 32'h1, 1'b1}) begin
            n_fail++;
            $display("FAIL mult_neg1: got stalls=%0d hi=%h lo=%h w=%b required 0/00000000/00000001/1", st, h, l, w);
        end
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd0, 32'hFFFF_FFFE, 32'h1, 1'b1}) begin
            n_fail++;
            $display("FAIL multu_max: got stalls=%0d hi=%h lo=%h w=%b required 0/fffffffe/00000001/1", st, h, l, w);
        end
    endtask

    task automatic test_div();
        int st, wbs; logic [31:0] h, l; logic w;
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if (st !== 33 || wbs !== 0) begin
            n_fail++;
            $display("FAIL div_latency: got stalls=%0d wb_during_stall=%0d required 33/0", st, wbs);
        end
        n_checks++;
        if ({h, l, w} !== {32'h1, 32'hFFFF_FFFD, 1'b1}) begin
            n_fail++;
            $display("FAIL div_7_m2: got hi=%h lo=%h w=%b required 00000001/fffffffd/1", h, l, w);
        end
        @(posedge clk); #1; aluop = OP_NOP;
        @(negedge clk);
        n_checks++;
        if (whilo !== 1'b0) begin
            n_fail++;
            $display("FAIL div_one_write: got whilo=%b required 0", whilo);
        end
    endtask

    task automatic test_divu_divzero();
        int st, wbs; logic [31:0] h, l; logic w;
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd33, 32'hF, 32'h0FFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL divu_max_16: got stalls=%0d hi=%h lo=%h w=%b required 33/0000000f/0fffffff/1", st, h, l, w);
        end
        do_op(OP_DIV, 32'd12345, 32'd0, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd1, 32'h0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL div_by_zero: got stalls=%0d hi=%h lo=%h w=%b required 1/0/0/1", st, h, l, w);
        end
        @(posedge clk); #1; aluop = OP_NOP;
    endtask

    task automatic test_mac();
        int st, wbs; logic [31:0] h, l; logic w;
        do_op(OP_MADD, 32'd3, 32'd4, 32'd0, 32'd5, st, wbs, h, l, w);
        n_checks++;
        if ({st, wbs, h, l, w} !== {32'd1, 32'd0, 32'd0, 32'd17, 1'b1}) begin
            n_fail++;
            $display("FAIL madd_basic: got stalls=%0d wbs=%0d hi=%h lo=%h w=%b required 1/0/0/17/1", st, wbs, h, l, w);
        end
        do_op(OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL msubu_wrap: got stalls=%0d hi=%h lo=%h w=%b required 1/ffffffff/ffffffff/1", st, h, l, w);
        end
        do_op(OP_MSUB, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, st, wbs, h, l, w);
        n_checks++;
        if ({h, l, w} !== {32'd0, 32'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL msub_signed: got hi=%h lo=%h w=%b required 0/0000000f/1", h, l, w);
        end
        @(posedge clk); #1; aluop = OP_NOP;
    endtask

    task automatic test_flush();
        int st, wbs, wcnt; logic [31:0] h, l; logic w;
        wcnt = 0;
        @(posedge clk); #1; aluop = OP_DIV; reg1 = 32'd1000; reg2 = 32'd3;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 10) flush = 1'b1;
            @(negedge clk);
            if (i < 10 && whilo) wcnt++;
        end
        n_checks++;
        if (stallreq !== 1'b0 || whilo !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got stallreq=%b whilo=%b required 0/0", stallreq, whilo);
        end
        @(posedge clk); #1; flush = 1'b0; aluop = OP_NOP;
        @(negedge clk);
        n_checks++;
        if (stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got stallreq=%b required 0", stallreq);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo) wcnt++;
        end
        n_checks++;
        if (wcnt !== 0) begin
            n_fail++;
            $display("FAIL flush_no_write: got %0d write cycles required 0", wcnt);
        end
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {32'd33, 32'd2, 32'd14, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_then_divu: got stalls=%0d hi=%h lo=%h w=%b required 33/2/14/1", st, h, l, w);
        end
        @(posedge clk); #1; aluop = OP_NOP;
    endtask

    task automatic test_hold();
        int st, wbs, est; logic [31:0] h, l, eh, el; logic w, ew;
        stall = 6'b01_0000;
        model(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 0, eh, el, ew, est);
        do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 0, st, wbs, h, l, w);
        n_checks++;
        if ({st, h, l, w} !== {est, eh, el, ew}) begin
            n_fail++;
            $display("FAIL hold_div_result: got stalls=%0d hi=%h lo=%h w=%b required %0d/%h/%h/%b", st, h, l, w, est, eh, el, ew);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if ({hi_out, lo_out, whilo, stallreq} !== {eh, el, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_stable: got hi=%h lo=%h w=%b s=%b required %h/%h/1/0", hi_out, lo_out, whilo, stallreq, eh, el);
            end
        end
        @(posedge clk); #1; stall = 6'd0;
        @(posedge clk); #1; aluop = OP_NOP;
        @(negedge clk);
        n_checks++;
        if (whilo !== 1'b0 || stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got whilo=%b stallreq=%b required 0/0", whilo, stallreq);
        end
    endtask

    task automatic test_rst_mid();
        int wcnt;
        wcnt = 0;
        @(posedge clk); #1; aluop = OP_DIV; reg1 = 32'd1234; reg2 = 32'd5;
        repeat (6) @(posedge clk);
        #1; rst = 1'b1; aluop = OP_NOP;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hi_out, lo_out, whilo, stallreq} !== 66'd0) begin
            n_fail++;
            $display("FAIL rst_mid_div: got hi=%h lo=%h w=%b s=%b required all zero", hi_out, lo_out, whilo, stallreq);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo || stallreq) wcnt++;
        end
        n_checks++;
        if (wcnt !== 0) begin
            n_fail++;
            $display("FAIL rst_no_resume: got %0d active cycles required 0", wcnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [9];
        logic [7:0] op;
        logic [31:0] a, b, hin, lin, h, l, eh, el;
        logic w, ew;
        int st, wbs, est;
        ops = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU, OP_NOP};
        for (int n = 0; n < 40; n++) begin
            op  = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if (n == 0) begin op = OP_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            hin = $urandom; lin = $urandom;
            model(op, a, b, hin, lin, eh, el, ew, est);
            do_op(op, a, b, hin, lin, st, wbs, h, l, w);
            n_checks++;
            if ({st, wbs} !== {est, 32'd0}) begin
                n_fail++;
                $display("FAIL rand_timing op=%h a=%h b=%h: got stalls=%0d wbs=%0d required %0d/0", op, a, b, st, wbs, est);
            end
            n_checks++;
            if ({h, l, w} !== {eh, el, ew}) begin
                n_fail++;
                $display("FAIL rand_result op=%h a=%h b=%h: got hi=%h lo=%h w=%b required %h/%h/%b", op, a, b, h, l, w, eh, el, ew);
            end
        end
        @(posedge clk); #1; aluop = OP_NOP;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divu_divzero();
        test_mac();
        test_flush();
        test_hold();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
